// File: rtl/alu_issue_unit.sv
// Issue/capture front end for a combinational ALU: decodes alu_op/funct3/funct7 into a 4-bit control code and registers the operands.
// Latency: 2 edges from acceptance to out_valid (accept -> EXEC -> DONE). Peak throughput is one op every 2 cycles.
// Backpressure: out_ready low holds DONE with stable outputs and in_ready low. A DONE handshake can accept the next op on the same edge.
// Ports: in_valid/in_ready + decoded fields in; alu_a/alu_b/alu_control out to the ALU; alu_result/zero_flag back;
//        out_valid/out_ready + result/branch_taken/illegal out; op_count counts output handshakes (wraps).
module alu_issue_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  input  logic             op_b5,
  input  logic             alu_src,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_control,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             zero_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             branch_taken,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic       accept;
  logic       handshake;
  logic [3:0] dec_ctrl;
  logic       dec_ill;
  logic [1:0] op_q;
  logic [2:0] f3_q;
  logic       ill_q;
  logic       br_dec;

  // Handshake control and next state
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
    handshake = out_valid && out_ready;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = DONE;
      DONE: begin
        if (out_ready) state_nxt = in_valid ? EXEC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control decode. Branch encodings other than BEQ/BNE are flagged here
  // so that the illegal bit is fully known at acceptance.
  always_comb begin
    dec_ctrl = CTRL_ADD;
    dec_ill  = 1'b0;
    case (alu_op)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: begin
        dec_ctrl = CTRL_SUB;
        if (funct3 != 3'b000 && funct3 != 3'b001) dec_ill = 1'b1;
      end
      2'b10: begin
        case (funct3)
          3'b000:  dec_ctrl = (funct7_b5 && op_b5) ? CTRL_SUB : CTRL_ADD;
          3'b010:  dec_ctrl = CTRL_SLT;
          3'b110:  dec_ctrl = CTRL_OR;
          3'b111:  dec_ctrl = CTRL_AND;
          default: dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Branch decision from the captured op and the ALU zero flag (SUB result)
  always_comb begin
    br_dec = 1'b0;
    if (op_q == 2'b01) begin
      if (f3_q == 3'b000)      br_dec = zero_flag;
      else if (f3_q == 3'b001) br_dec = !zero_flag;
    end
  end

  // Operand/control registers: change only on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= CTRL_ADD;
      op_q        <= 2'b00;
      f3_q        <= 3'b000;
      ill_q       <= 1'b0;
    end else if (accept) begin
      alu_a       <= rs1_data;
      alu_b       <= alu_src ? imm : rs2_data;
      alu_control <= dec_ctrl;
      op_q        <= alu_op;
      f3_q        <= funct3;
      ill_q       <= dec_ill;
    end
  end

  // Result registers: loaded only at the end of EXEC, so they hold through DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result       <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else if (state == EXEC) begin
      result       <= alu_result;
      branch_taken <= br_dec;
      illegal      <= ill_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          op_count <= '0;
    else if (handshake) op_count <= op_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural combinational ALU attached.
// The counter width is reduced so the wrap from all-ones to zero is reachable in a short run.
module tb_alu_issue_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       alu_op = 2'b00;
  logic [2:0]       funct3 = 3'b000;
  logic             funct7_b5 = 1'b0;
  logic             op_b5 = 1'b0;
  logic             alu_src = 1'b0;
  logic [XLEN-1:0]  rs1_data = '0;
  logic [XLEN-1:0]  rs2_data = '0;
  logic [XLEN-1:0]  imm = '0;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic [3:0]       alu_control;
  logic [XLEN-1:0]  alu_result;
  logic             zero_flag;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  result;
  logic             branch_taken;
  logic             illegal;
  logic [CNT_W-1:0] op_count;

  int               n_checks = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  alu_issue_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_b5(funct7_b5), .op_b5(op_b5),
    .alu_src(alu_src), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .zero_flag(zero_flag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .illegal(illegal), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1000: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
    zero_flag = (alu_result == '0);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic ob5, input logic src, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] im);
    alu_op = op; funct3 = f3; funct7_b5 = f7; op_b5 = ob5; alu_src = src;
    rs1_data = a; rs2_data = b; imm = im; in_valid = 1'b1;
  endtask

  // Accept, execute, then sit in DONE (no checks)
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic ob5, input logic src, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] im);
    drive(op, f3, f7, ob5, src, a, b, im);
    step;
    in_valid = 1'b0;
    step;
  endtask

  // Handshake from DONE back to IDLE
  task automatic finish_op;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step;
    exp_cnt++;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (alu_control !== 4'b0010) begin n_fail++; $display("FAIL rst_alu_control: got %b want 0010", alu_control); end
    n_checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin n_fail++; $display("FAIL rst_operands: got %h/%h want 0/0", alu_a, alu_b); end
    n_checks++; if (result !== 32'd0 || branch_taken !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL rst_result: got %h/%b/%b want 0/0/0", result, branch_taken, illegal); end
    n_checks++; if (op_count !== '0) begin n_fail++; $display("FAIL rst_op_count: got %h want 0", op_count); end
    #6 reset = 1'b0;
    step;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_r_sub;
    drive(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 32'd7, 32'd7, 32'd99);
    step;
    in_valid = 1'b0;
    n_checks++; if (alu_control !== 4'b0110) begin n_fail++; $display("FAIL sub_ctrl: got %b want 0110", alu_control); end
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL sub_exec: got out_valid=%b in_ready=%b want 0/0", out_valid, in_ready); end
    step;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_latency: got out_valid=%b want 1", out_valid); end
    n_checks++; if (result !== 32'd0 || illegal !== 1'b0 || branch_taken !== 1'b0) begin n_fail++; $display("FAIL sub_result: got %h/%b/%b want 0/0/0", result, illegal, branch_taken); end
    finish_op;
    n_checks++; if (op_count !== exp_cnt || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL sub_handoff: got cnt=%h ov=%b ir=%b want %h/0/1", op_count, out_valid, in_ready, exp_cnt); end
  endtask

  task automatic test_addi;
    issue(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd100, 32'd3);
    n_checks++; if (alu_control !== 4'b0010) begin n_fail++; $display("FAIL addi_ctrl: got %b want 0010", alu_control); end
    n_checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin n_fail++; $display("FAIL addi_operands: got %h/%h want 5/3", alu_a, alu_b); end
    n_checks++; if (result !== 32'd8 || illegal !== 1'b0) begin n_fail++; $display("FAIL addi_result: got %h/%b want 8/0", result, illegal); end
    finish_op;
  endtask

  task automatic test_logic_slt;
    issue(2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 32'h0000F0F0, 32'h00000FF0, 32'd0);
    n_checks++; if (alu_control !== 4'b0000 || result !== 32'h000000F0) begin n_fail++; $display("FAIL and_op: got %b/%h want 0000/000000f0", alu_control, result); end
    finish_op;
    issue(2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 32'h0000F0F0, 32'h00000FF0, 32'd0);
    n_checks++; if (alu_control !== 4'b0001 || result !== 32'h0000FFF0) begin n_fail++; $display("FAIL or_op: got %b/%h want 0001/0000fff0", alu_control, result); end
    finish_op;
    issue(2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
    n_checks++; if (alu_control !== 4'b1000 || result !== 32'd1) begin n_fail++; $display("FAIL slt_signed: got %b/%h want 1000/1", alu_control, result); end
    finish_op;
    issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd40, 32'd2, 32'd0);
    n_checks++; if (alu_control !== 4'b0010 || result !== 32'd42) begin n_fail++; $display("FAIL r_add: got %b/%h want 0010/2a", alu_control, result); end
    finish_op;
    issue(2'b00, 3'b010, 1'b1, 1'b1, 1'b1, 32'h100, 32'd0, 32'h20);
    n_checks++; if (alu_control !== 4'b0010 || result !== 32'h120 || illegal !== 1'b0) begin n_fail++; $display("FAIL mem_add: got %b/%h/%b want 0010/120/0", alu_control, result, illegal); end
    finish_op;
    n_checks++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL logic_count: got %h want %h", op_count, exp_cnt); end
  endtask

  task automatic test_branch;
    issue(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'd0);
    n_checks++; if (alu_control !== 4'b0110 || branch_taken !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL beq_equal: got %b/%b/%b want 0110/1/0", alu_control, branch_taken, illegal); end
    finish_op;
    issue(2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'd0);
    n_checks++; if (branch_taken !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL bne_equal: got %b/%b want 0/0", branch_taken, illegal); end
    finish_op;
    issue(2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1235, 32'd0);
    n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL bne_differ: got %b want 1", branch_taken); end
    finish_op;
    issue(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1235, 32'd0);
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL beq_differ: got %b want 0", branch_taken); end
    finish_op;
    issue(2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 32'h5, 32'h5, 32'd0);
    n_checks++; if (branch_taken !== 1'b0 || illegal !== 1'b1) begin n_fail++; $display("FAIL br_bad_f3: got %b/%b want 0/1", branch_taken, illegal); end
    finish_op;
  endtask

  task automatic test_back_to_back;
    logic [CNT_W-1:0] cnt_before;
    drive(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd100, 32'd23, 32'd0);
    step;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step;
    cnt_before = exp_cnt;
    drive(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 32'd50, 32'd8, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_%0d: got ov=%b ir=%b want 1/0", i, out_valid, in_ready); end
      n_checks++; if (result !== 32'd123 || alu_a !== 32'd100) begin n_fail++; $display("FAIL bp_stable_%0d: got result=%h alu_a=%h want 7b/64", i, result, alu_a); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    step;
    exp_cnt++;
    in_valid = 1'b0;
    n_checks++; if (op_count !== cnt_before + CNT_W'(1)) begin n_fail++; $display("FAIL b2b_count: got %h want %h", op_count, cnt_before + CNT_W'(1)); end
    n_checks++; if (out_valid !== 1'b0 || alu_a !== 32'd50 || alu_control !== 4'b0110) begin n_fail++; $display("FAIL b2b_accept: got ov=%b a=%h ctrl=%b want 0/32/0110", out_valid, alu_a, alu_control); end
    step;
    n_checks++; if (out_valid !== 1'b1 || result !== 32'd42) begin n_fail++; $display("FAIL b2b_result: got ov=%b result=%h want 1/2a", out_valid, result); end
    finish_op;
    n_checks++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL b2b_final_count: got %h want %h", op_count, exp_cnt); end
  endtask

  task automatic test_reset_midflight;
    // Reset during EXEC
    drive(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd9, 32'd9, 32'd0);
    step;
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (alu_a !== 32'd0 || alu_control !== 4'b0010 || op_count !== '0) begin n_fail++; $display("FAIL rst_exec: got a=%h ctrl=%b cnt=%h want 0/0010/0", alu_a, alu_control, op_count); end
    #1 reset = 1'b0;
    exp_cnt = '0;
    step;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_exec_dropped: got ov=%b ir=%b want 0/1", out_valid, in_ready); end
    // Reset during DONE with a taken branch waiting
    out_ready = 1'b0;
    issue(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0);
    n_checks++; if (out_valid !== 1'b1 || branch_taken !== 1'b1) begin n_fail++; $display("FAIL rst_done_pre: got ov=%b bt=%b want 1/1", out_valid, branch_taken); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || branch_taken !== 1'b0 || result !== 32'd0) begin n_fail++; $display("FAIL rst_done: got ov=%b bt=%b res=%h want 0/0/0", out_valid, branch_taken, result); end
    #1 reset = 1'b0;
    out_ready = 1'b1;
    step;
    step;
    n_checks++; if (op_count !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done_no_count: got cnt=%h ov=%b want 0/0", op_count, out_valid); end
  endtask

  task automatic test_illegal_wrap;
    issue(2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 32'd10, 32'd20, 32'd0);
    n_checks++; if (illegal !== 1'b1 || alu_control !== 4'b0010 || result !== 32'd30) begin n_fail++; $display("FAIL ill_f3: got ill=%b ctrl=%b res=%h want 1/0010/1e", illegal, alu_control, result); end
    finish_op;
    n_checks++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL ill_handshake: got %h want %h", op_count, exp_cnt); end
    issue(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0);
    n_checks++; if (illegal !== 1'b1 || alu_control !== 4'b0010 || result !== 32'd3 || branch_taken !== 1'b0) begin n_fail++; $display("FAIL ill_op11: got ill=%b ctrl=%b res=%h bt=%b want 1/0010/3/0", illegal, alu_control, result, branch_taken); end
    finish_op;
    while (exp_cnt != {CNT_W{1'b1}}) begin
      issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0);
      finish_op;
    end
    n_checks++; if (op_count !== {CNT_W{1'b1}}) begin n_fail++; $display("FAIL cnt_all_ones: got %h want %h", op_count, {CNT_W{1'b1}}); end
    issue(2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 32'd4, 32'd4, 32'd0);
    n_checks++; if (illegal !== 1'b1 || result !== 32'd8) begin n_fail++; $display("FAIL ill_f3_101: got ill=%b res=%h want 1/8", illegal, result); end
    finish_op;
    n_checks++; if (op_count !== '0) begin n_fail++; $display("FAIL cnt_wrap: got %h want 0", op_count); end
  endtask

  initial begin
    test_reset;
    test_r_sub;
    test_addi;
    test_logic_slt;
    test_branch;
    test_back_to_back;
    test_reset_midflight;
    test_illegal_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
